// File: rtl/mem_stage_if.sv
// Signal bundle between the execute stage, the memory stage and the write-back stage.
// The master side drives execute results and pipeline control; the slave side is the memory stage.
interface mem_stage_if;
  logic        valid_in;
  logic [31:0] Instruction_in;
  logic [31:0] alu_result_in;
  logic [31:0] store_data_in;
  logic [4:0]  dest_in;
  logic        mem_read_in;
  logic        mem_write_in;
  logic        wb_en_in;
  logic        freeze;
  logic        flush;

  logic        valid_out;
  logic [31:0] Instruction;
  logic [31:0] wb_data;
  logic [4:0]  dest;
  logic        wb_en;
  logic        misaligned;

  modport master (
    output valid_in, Instruction_in, alu_result_in, store_data_in, dest_in,
           mem_read_in, mem_write_in, wb_en_in, freeze, flush,
    input  valid_out, Instruction, wb_data, dest, wb_en, misaligned
  );

  modport slave (
    input  valid_in, Instruction_in, alu_result_in, store_data_in, dest_in,
           mem_read_in, mem_write_in, wb_en_in, freeze, flush,
    output valid_out, Instruction, wb_data, dest, wb_en, misaligned
  );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, private word-addressed data memory and MEM/WB register.
// Supports freeze (hold both registers) and flush (bubble into EX/MEM); flags misaligned accesses.
module mem_stage #(
  parameter int DEPTH = 64
) (
  input  logic     clk,
  input  logic     rst,
  mem_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("mem_stage: DEPTH must be a power of two >= 2");
  end

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [4:0]  dest;
    logic        rd;
    logic        wr;
    logic        wb_en;
  } ex_mem_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] wb_data;
    logic [4:0]  dest;
    logic        wb_en;
    logic        misaligned;
  } mem_wb_t;

  ex_mem_t     r_ex;
  mem_wb_t     r_wb;
  mem_wb_t     w_wb_next;
  logic [31:0] r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic          w_aligned;
  logic          w_misaligned;
  logic          w_mem_we;
  logic [31:0]   w_load;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex <= '0;
    end else if (bus.flush) begin
      r_ex <= '0;
    end else if (!bus.freeze) begin
      r_ex <= '{valid: bus.valid_in,     instr: bus.Instruction_in,
                addr:  bus.alu_result_in, sdata: bus.store_data_in,
                dest:  bus.dest_in,       rd:    bus.mem_read_in,
                wr:    bus.mem_write_in,  wb_en: bus.wb_en_in};
    end
  end

  assign w_idx        = r_ex.addr[AW+1:2];
  assign w_aligned    = (r_ex.addr[1:0] == 2'b00);
  assign w_misaligned = r_ex.valid & (r_ex.rd | r_ex.wr) & ~w_aligned;
  assign w_load       = r_mem[w_idx];

  // A frozen store writes only on the edge it leaves EX/MEM; reset drops an in-flight store.
  assign w_mem_we = rst & ~bus.freeze & r_ex.valid & r_ex.wr & w_aligned;

  // NOTE: the memory array has no reset; contents survive reset and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_idx] <= r_ex.sdata;
    end
  end

  // NOTE: defaults first so every path assigns every field and no latch is inferred.
  always_comb begin
    w_wb_next            = '0;
    w_wb_next.valid      = r_ex.valid;
    w_wb_next.instr      = r_ex.instr;
    w_wb_next.dest       = r_ex.dest;
    w_wb_next.misaligned = w_misaligned;
    w_wb_next.wb_data    = r_ex.addr;
    if (r_ex.rd) begin
      w_wb_next.wb_data = w_misaligned ? 32'h0 : w_load;
    end
    w_wb_next.wb_en = r_ex.valid & r_ex.wb_en & ~w_misaligned & ~(r_ex.rd & r_ex.wr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wb <= '0;
    end else if (!bus.freeze) begin
      r_wb <= w_wb_next;
    end
  end

  assign bus.valid_out   = r_wb.valid;
  assign bus.Instruction = r_wb.instr;
  assign bus.wb_data     = r_wb.wb_data;
  assign bus.dest        = r_wb.dest;
  assign bus.wb_en       = r_wb.wb_en;
  assign bus.misaligned  = r_wb.misaligned;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a short random run,
// checked against a scoreboard holding the instruction expected to leave EX/MEM next.
module tb_mem_stage;
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [4:0]  dest;
    logic        rd;
    logic        wr;
    logic        wben;
  } stim_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] wb_data;
    logic [4:0]  dest;
    logic        wb_en;
    logic        mis;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();
  mem_stage #(.DEPTH(64)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_step   = 0;
  int          seq      = 0;
  stim_t       q[$];
  out_t        exp_last = '0;
  logic [31:0] m_mem [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL step %0d %s: got %h expected %h", n_step, tag, got, exp);
    end
  endtask

  function automatic stim_t mk(bit rd, bit wr, bit wben, logic [31:0] addr,
                               logic [31:0] sd, logic [4:0] dest);
    stim_t s;
    seq++;
    s.valid = 1'b1;
    s.instr = 32'hA500_0000 | 32'(seq);
    s.addr  = addr;
    s.sd    = sd;
    s.dest  = dest;
    s.rd    = rd;
    s.wr    = wr;
    s.wben  = wben;
    return s;
  endfunction

  function automatic stim_t st(logic [31:0] addr, logic [31:0] sd);
    return mk(1'b0, 1'b1, 1'b0, addr, sd, 5'd0);
  endfunction
  function automatic stim_t ld(logic [31:0] addr, logic [4:0] dest);
    return mk(1'b1, 1'b0, 1'b1, addr, 32'h0, dest);
  endfunction
  function automatic stim_t alu(logic [31:0] val, logic [4:0] dest);
    return mk(1'b0, 1'b0, 1'b1, val, 32'h0, dest);
  endfunction

  // Result of an instruction leaving EX/MEM; commits its store to the reference memory.
  function automatic out_t model(stim_t e);
    out_t       o;
    logic [5:0] idx = e.addr[7:2];
    logic       mis = e.valid & (e.rd | e.wr) & (e.addr[1:0] != 2'b00);
    o.valid   = e.valid;
    o.instr   = e.instr;
    o.dest    = e.dest;
    o.mis     = mis;
    o.wb_data = e.rd ? (mis ? 32'h0 : m_mem[idx]) : e.addr;
    o.wb_en   = e.valid & e.wben & ~mis & ~(e.rd & e.wr);
    if (e.valid && e.wr && !mis) m_mem[idx] = e.sd;
    return o;
  endfunction

  // One clock: drive at the falling edge, update the scoreboard at the rising edge, check 1 time unit later.
  task automatic step(input stim_t s, input bit frz, input bit fl, input bit rst_v);
    stim_t e;
    n_step++;
    rst                = rst_v;
    bus.valid_in       = s.valid;
    bus.Instruction_in = s.instr;
    bus.alu_result_in  = s.addr;
    bus.store_data_in  = s.sd;
    bus.dest_in        = s.dest;
    bus.mem_read_in    = s.rd;
    bus.mem_write_in   = s.wr;
    bus.wb_en_in       = s.wben;
    bus.freeze         = frz;
    bus.flush          = fl;
    @(posedge clk);
    if (!rst_v) begin
      q.delete();
      q.push_back('0);
      exp_last = '0;
    end else if (q.size() == 0) begin
      check("scoreboard_empty", 32'(q.size()), 32'd1);
    end else if (frz) begin
      if (fl) begin
        void'(q.pop_front());
        q.push_back('0);
      end
    end else begin
      e        = q.pop_front();
      exp_last = model(e);
      q.push_back(fl ? stim_t'('0) : s);
    end
    #1;
    check("valid_out",   32'(bus.valid_out),  32'(exp_last.valid));
    check("Instruction", bus.Instruction,     exp_last.instr);
    check("wb_data",     bus.wb_data,         exp_last.wb_data);
    check("dest",        32'(bus.dest),       32'(exp_last.dest));
    check("wb_en",       32'(bus.wb_en),      32'(exp_last.wb_en));
    check("misaligned",  32'(bus.misaligned), 32'(exp_last.mis));
    @(negedge clk);
  endtask

  task automatic go(input stim_t s);
    step(s, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    stim_t idle = '0;
    @(negedge clk);
    // Reset held for two cycles with a live instruction at the inputs.
    step(st(32'h10, 32'h0BAD_0BAD), 1'b0, 1'b0, 1'b0);
    step(st(32'h10, 32'h0BAD_0BAD), 1'b0, 1'b0, 1'b0);

    // Store then load to the same word on the next cycle.
    go(st(32'h10, 32'hDEAD_BEEF));
    go(ld(32'h10, 5'd5));
    // Address wrap and ALU pass-through.
    go(st(32'h100, 32'h1234));
    go(ld(32'h000, 5'd6));
    go(alu(32'h55, 5'd7));
    // Misaligned store must not write; misaligned load returns zero.
    go(st(32'h20, 32'hAAAA));
    go(st(32'h22, 32'hBBBB));
    go(ld(32'h21, 5'd8));
    go(ld(32'h20, 5'd9));
    // Freeze for three cycles with a store in EX/MEM.
    go(st(32'h30, 32'h11));
    go(st(32'h40, 32'hCAFE));
    for (int i = 0; i < 3; i++) step(ld(32'h44, 5'd1), 1'b1, 1'b0, 1'b1);
    go(ld(32'h40, 5'd10));
    // Flush drops the store at the inputs.
    step(st(32'h30, 32'h77), 1'b0, 1'b1, 1'b1);
    go(ld(32'h30, 5'd11));
    // Flush with freeze: EX/MEM instruction replaced by a bubble, MEM/WB holds.
    go(alu(32'h99, 5'd12));
    step(idle, 1'b1, 1'b1, 1'b1);
    go(idle);
    // Load and store together: store happens, old word returned, no write-back.
    go(mk(1'b1, 1'b1, 1'b1, 32'h10, 32'h5555, 5'd13));
    go(ld(32'h10, 5'd14));
    // In-flight store dropped by reset; memory preserved across reset.
    go(st(32'h50, 32'h1));
    go(st(32'h50, 32'h6666));
    step(idle, 1'b0, 1'b0, 1'b0);
    go(ld(32'h50, 5'd15));
    go(ld(32'h10, 5'd16));
    go(idle);

    // Random mix over words 0..7 with wrapped addresses, freeze and flush.
    for (int w = 0; w < 8; w++) go(st(32'(w) << 2, 32'hF000_0000 | 32'(w)));
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      int          kind;
      stim_t       s;
      a    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 5) == 0) a = a | 32'($urandom_range(1, 3));
      kind = $urandom_range(0, 4);
      case (kind)
        0:       s = st(a, $urandom());
        1, 2:    s = ld(a, 5'($urandom_range(1, 31)));
        3:       s = mk(1'b1, 1'b1, 1'b1, a, $urandom(), 5'd3);
        default: s = alu($urandom(), 5'($urandom_range(0, 31)));
      endcase
      step(s, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, 1'b1);
    end
    go(idle);
    go(idle);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage pipeline, directly downstream of the execute stage. It registers the execute stage's results into an EX/MEM pipeline register and performs word loads and stores against a private synchronous data memory. It then registers the write-back payload into a MEM/WB register for the write-back stage. It supports pipeline freeze (stall) and flush (bubble insertion) and flags misaligned accesses.

## Interface
- DEPTH, 64: data memory size in 32-bit words; must be a power of two ≥ 2. AW = log2(DEPTH).
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-low (0 = reset at the rising edge).
- valid_in  in  1  execute stage presents a real instruction.
- Instruction_in  in  32  instruction word from execute stage, carried through.
- alu_result_in  in  32  ALU result; used as the byte address for loads and stores.
- store_data_in  in  32  store data.
- dest_in  in  5  destination register number.
- mem_read_in  in  1  load.
- mem_write_in  in  1  store.
- wb_en_in  in  1  instruction writes the register file.
- freeze  in  1  hold both pipeline registers.
- flush  in  1  load a bubble into EX/MEM.
- valid_out  out  1  MEM/WB holds a real instruction.
- Instruction  out  32  instruction in MEM/WB.
- wb_data  out  32  load data or ALU result.
- dest  out  5  destination register.
- wb_en  out  1  register-file write enable for the write-back stage.
- misaligned  out  1  MEM/WB instruction was a misaligned load or store.

## Operation
- **EX/MEM register** captures all `*_in` fields each edge. Priority, high to low:
  - rst = 0: load all zeros.
  - flush: load a bubble (all fields zero, valid = 0).
  - freeze: hold.
  - otherwise: capture.
- **Memory addressing**
  - Word index = EX/MEM address[AW+1:2]. Upper address bits are ignored, so addresses wrap modulo 4·DEPTH bytes.
  - The access is misaligned when address[1:0] ≠ 0.
- **Read path**: combinational read of mem[index] from the EX/MEM address.
- **Write path**: mem[index] ← store data at the edge. The write occurs only when all of these hold:
  - EX/MEM valid;
  - mem_write;
  - the access is aligned;
  - freeze = 0;
  - rst = 1.
- Because writes are gated by freeze, a store held by freeze writes exactly once, on the edge on which it leaves EX/MEM.
- **mem_read and mem_write both set**: the store is performed and wb_en is forced to 0.
- **MEM/WB register** priority, high to low:
  - rst = 0: load zeros.
  - freeze: hold.
  - otherwise: capture from EX/MEM.
- **MEM/WB field values**:
  - wb_data = loaded word if mem_read, else the ALU result.
  - For a misaligned load, wb_data = 0.
  - misaligned = valid & (mem_read | mem_write) & (address[1:0] ≠ 0).
  - wb_en = valid & wb_en_in & ~misaligned & ~(mem_read & mem_write).
- **Bubbles** (valid = 0) never write memory and always produce wb_en = 0 and misaligned = 0.
- **Reset**
  - All outputs are 0 while in reset and after it.
  - Memory contents are not reset; they are undefined at power-up and preserved across reset.
  - An in-flight store whose write edge coincides with rst = 0 is dropped.

## Timing
- Latency is 2 edges. Inputs sampled at edge k appear on the outputs after edge k+1.
- The memory write happens at edge k+1.
- A load issued one cycle after a store to the same word reads the new data: the store writes at edge k+1, and the load reads combinationally during the following cycle.
- Freeze held for n cycles adds n cycles of latency with no loss or duplication of instructions.
- With flush and freeze asserted together: EX/MEM takes a bubble and MEM/WB holds.
- No combinational path from any input to any output.

## Test plan
- Reset: drive rst = 0 for 2 cycles with valid_in = 1 → all outputs 0. Release rst → first instruction appears 2 edges later.
- Store/load: store 0xDEADBEEF to address 0x10, then load from 0x10 on the next cycle. Expect:
  - store: wb_en = 0;
  - load: wb_data = 0xDEADBEEF, wb_en = 1, dest matches dest_in.
- Wrap and ALU pass-through (DEPTH = 64):
  - store 0x1234 to 0x100 → load from 0x000 returns 0x1234;
  - non-memory instruction with alu_result_in = 0x55 and wb_en_in = 1 → wb_data = 0x55.
- Misaligned: store 0xAAAA to 0x20, then store 0xBBBB to 0x22, then load from 0x21. Expect:
  - word 0x20 still holds 0xAAAA;
  - both misaligned accesses give misaligned = 1 and wb_en = 0;
  - misaligned load gives wb_data = 0.
- Freeze: hold freeze = 1 for 3 cycles with a store in EX/MEM. Expect:
  - outputs are constant during freeze;
  - the store writes exactly once, after release;
  - the instruction sequence is intact.
- Flush: flush = 1 with a store at the inputs. Expect:
  - the store never writes;
  - the corresponding output slot has valid_out = 0 and wb_en = 0;
  - with flush and freeze asserted together, MEM/WB holds its value.
